// File: rtl/gpin_sync_debounce.sv
// -----------------------------------------------------------------------------
// gpin_sync_debounce
//
// Cleans up a raw general-purpose input coming straight from the pad tile.
// The asynchronous pad level is first brought into the clk domain through a
// SYNC_STAGES-deep flop chain. A four-state debounce FSM then requires the
// synchronized level to remain stable for a programmable number of cycles
// before it is accepted. Accepted transitions raise one-cycle rise/fall
// pulses, and a saturating counter tallies them.
//
// Ports:
//   clk          fabric clock
//   RSTN         asynchronous active-low reset
//   inpad_inpad  raw pad value, asynchronous to clk
//   db_limit     stable-sample count needed to accept a change (quasi-static)
//   db_bypass    1 = debounced level follows the synchronized level directly
//   evt_clr      synchronous clear of evt_cnt (wins over an increment)
//   sync_out     synchronized raw value (last synchronizer stage)
//   db_out       debounced level
//   rise_pulse   one-cycle pulse when db_out goes 0->1
//   fall_pulse   one-cycle pulse when db_out goes 1->0
//   evt_cnt      saturating count of accepted db_out transitions
// -----------------------------------------------------------------------------
module gpin_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int EVT_W       = 16
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic             inpad_inpad,
    input  logic [CNT_W-1:0] db_limit,
    input  logic             db_bypass,
    input  logic             evt_clr,
    output logic             sync_out,
    output logic             db_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_ZERO = {EVT_W{1'b0}};
    localparam logic [EVT_W-1:0] EVT_ONE  = {{(EVT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};

    typedef enum logic [1:0] {
        S_LO     = 2'b00,
        S_CHK_HI = 2'b01,
        S_HI     = 2'b10,
        S_CHK_LO = 2'b11
    } state_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        logic [EVT_W-1:0] r;
        if (v == EVT_MAX) begin
            r = v;
        end else begin
            r = v + EVT_ONE;
        end
        return r;
    endfunction

    // The debounced level is high in the accepted-high state and while a
    // high-to-low change is still being qualified.
    function automatic logic level_of(input state_t s);
        logic r;
        case (s)
            S_HI:     r = 1'b1;
            S_CHK_LO: r = 1'b1;
            S_LO:     r = 1'b0;
            S_CHK_HI: r = 1'b0;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   sync_s;
    logic                   db_nxt_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;
    logic                   db_out_r;
    logic                   rise_r;
    logic                   fall_r;
    logic [EVT_W-1:0]       evt_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain: shift the pad value in at stage 0.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], inpad_inpad};
        end
    end

    // Debounce next-state and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (db_bypass) begin
            // Track the synchronized level directly; keep the counter idle so
            // leaving bypass starts from a clean stable state.
            state_nxt_s = sync_s ? S_HI : S_LO;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                S_LO: begin
                    if (sync_s) begin
                        state_nxt_s = S_CHK_HI;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                S_CHK_HI: begin
                    if (!sync_s) begin
                        state_nxt_s = S_LO;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r >= db_limit) begin
                        // >= keeps a lowered limit mid-window from stranding
                        // the counter above the new threshold.
                        state_nxt_s = S_HI;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                S_HI: begin
                    if (!sync_s) begin
                        state_nxt_s = S_CHK_LO;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                S_CHK_LO: begin
                    if (sync_s) begin
                        state_nxt_s = S_HI;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r >= db_limit) begin
                        state_nxt_s = S_LO;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = S_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Edge detection on the level the FSM is about to present, so pulses
    // register in the same cycle db_out first shows the new level.
    always_comb begin
        db_nxt_s   = level_of(state_nxt_s);
        rise_nxt_s = db_nxt_s & ~db_out_r;
        fall_nxt_s = ~db_nxt_s & db_out_r;
    end

    // FSM state, counter, debounced level and pulse registers.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_r  <= S_LO;
            cnt_r    <= CNT_ZERO;
            db_out_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            db_out_r <= db_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
        end
    end

    // Event counter: clear wins over a coincident pulse, otherwise saturate.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            evt_r <= EVT_ZERO;
        end else if (evt_clr) begin
            evt_r <= EVT_ZERO;
        end else if (rise_r || fall_r) begin
            evt_r <= sat_inc(evt_r);
        end else begin
            evt_r <= evt_r;
        end
    end

    assign sync_out   = sync_s;
    assign db_out     = db_out_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign evt_cnt    = evt_r;

endmodule

// File: tb/tb_gpin_sync_debounce.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for gpin_sync_debounce. A default-width
// instance carries the main checks; a second instance with a 4-bit event
// counter shares the stimulus and shows counter saturation.
// -----------------------------------------------------------------------------
module tb_gpin_sync_debounce;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        inpad;
    logic [7:0]  db_limit;
    logic        bypass;
    logic        evt_clr;
    logic        evt_clr4;

    logic        sync_out, db_out, rise_pulse, fall_pulse;
    logic [15:0] evt_cnt;
    logic        sync_out4, db_out4, rise_pulse4, fall_pulse4;
    logic [3:0]  evt_cnt4;

    int n_assert = 0;
    int n_fail   = 0;
    int rise_seen = 0;
    int fall_seen = 0;
    int both_seen = 0;

    gpin_sync_debounce #(.SYNC_STAGES(2), .CNT_W(8), .EVT_W(16)) dut (
        .clk(clk), .RSTN(RSTN), .inpad_inpad(inpad), .db_limit(db_limit),
        .db_bypass(bypass), .evt_clr(evt_clr), .sync_out(sync_out),
        .db_out(db_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .evt_cnt(evt_cnt)
    );

    gpin_sync_debounce #(.SYNC_STAGES(2), .CNT_W(8), .EVT_W(4)) dut4 (
        .clk(clk), .RSTN(RSTN), .inpad_inpad(inpad), .db_limit(db_limit),
        .db_bypass(bypass), .evt_clr(evt_clr4), .sync_out(sync_out4),
        .db_out(db_out4), .rise_pulse(rise_pulse4), .fall_pulse(fall_pulse4),
        .evt_cnt(evt_cnt4)
    );

    always #5 clk = ~clk;

    // Tally pulses away from the active edge.
    always @(negedge clk) begin
        if (rise_pulse) rise_seen <= rise_seen + 1;
        if (fall_pulse) fall_seen <= fall_seen + 1;
        if (rise_pulse && fall_pulse) both_seen <= both_seen + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic old_lvl;

    initial begin
        RSTN = 1'b0; inpad = 1'b1; db_limit = 8'd4;
        bypass = 1'b0; evt_clr = 1'b0; evt_clr4 = 1'b0;
        tick(3);
        chk("rst_sync",  {31'd0, sync_out},   32'd0);
        chk("rst_db",    {31'd0, db_out},     32'd0);
        chk("rst_rise",  {31'd0, rise_pulse}, 32'd0);
        chk("rst_fall",  {31'd0, fall_pulse}, 32'd0);
        chk("rst_evt",   {16'd0, evt_cnt},    32'd0);
        chk("rst_evt4",  {28'd0, evt_cnt4},   32'd0);

        // Release with input held high: fresh 0->1 step.
        RSTN = 1'b1;
        tick(1); chk("sync_e1", {31'd0, sync_out}, 32'd0);
        tick(1); chk("sync_e2", {31'd0, sync_out}, 32'd1);
        tick(4); chk("db_e6",   {31'd0, db_out},   32'd0);
        tick(1); chk("db_e7",   {31'd0, db_out},   32'd1);
        chk("rise_e7", {31'd0, rise_pulse}, 32'd1);
        tick(1); chk("rise_e8", {31'd0, rise_pulse}, 32'd0);
        chk("evt_e8",  {16'd0, evt_cnt}, 32'd1);
        chk("rise_cnt1", rise_seen, 32'd1);

        // Clean falling step, limit 4.
        inpad = 1'b0;
        tick(6); chk("fall_db_e6", {31'd0, db_out}, 32'd1);
        tick(1); chk("fall_db_e7", {31'd0, db_out}, 32'd0);
        chk("fall_e7", {31'd0, fall_pulse}, 32'd1);
        tick(1); chk("fall_e8", {31'd0, fall_pulse}, 32'd0);
        chk("evt_2", {16'd0, evt_cnt}, 32'd2);

        // 3-cycle high is rejected.
        inpad = 1'b1; tick(3); inpad = 1'b0; tick(10);
        chk("glitch_db",  {31'd0, db_out},  32'd0);
        chk("glitch_evt", {16'd0, evt_cnt}, 32'd2);
        chk("glitch_rise", rise_seen, 32'd1);

        // 5-cycle high is accepted, then falls back.
        inpad = 1'b1; tick(5); inpad = 1'b0;
        tick(1); chk("acc5_db_e6", {31'd0, db_out}, 32'd0);
        tick(1); chk("acc5_db_e7", {31'd0, db_out}, 32'd1);
        chk("acc5_rise", {31'd0, rise_pulse}, 32'd1);
        tick(10);
        chk("acc5_back", {31'd0, db_out},  32'd0);
        chk("acc5_evt",  {16'd0, evt_cnt}, 32'd4);
        chk("acc5_fallcnt", fall_seen, 32'd2);

        // db_limit 1 and 0 behave identically: 2-cycle high accepted.
        for (int k = 0; k < 2; k++) begin
            db_limit = (k == 0) ? 8'd1 : 8'd0;
            inpad = 1'b1; tick(2); inpad = 1'b0;
            tick(1); chk("lim_db_e3", {31'd0, db_out}, 32'd0);
            tick(1); chk("lim_db_e4", {31'd0, db_out}, 32'd1);
            chk("lim_rise", {31'd0, rise_pulse}, 32'd1);
            tick(1); chk("lim_db_e5", {31'd0, db_out}, 32'd1);
            chk("lim_rise_w", {31'd0, rise_pulse}, 32'd0);
            tick(1); chk("lim_db_e6", {31'd0, db_out}, 32'd0);
            chk("lim_fall", {31'd0, fall_pulse}, 32'd1);
            tick(4); chk("lim_evt", {16'd0, evt_cnt}, 32'd6 + 32'(2 * k));
        end

        // All-ones limit: 255-cycle window, no wrap.
        db_limit = 8'hFF; inpad = 1'b1;
        tick(257); chk("max_db_e257", {31'd0, db_out}, 32'd0);
        tick(1);   chk("max_db_e258", {31'd0, db_out}, 32'd1);
        chk("max_rise", {31'd0, rise_pulse}, 32'd1);
        db_limit = 8'd4; inpad = 1'b0;
        tick(7); chk("max_fall", {31'd0, fall_pulse}, 32'd1);
        tick(1); chk("evt_10", {16'd0, evt_cnt}, 32'd10);

        // Bypass: 10 toggles every 3 cycles, db_out = input delayed 3 edges.
        bypass = 1'b1; tick(2);
        old_lvl = inpad;
        for (int i = 0; i < 10; i++) begin
            inpad = ~inpad;
            tick(2); chk("byp_hold", {31'd0, db_out}, {31'd0, old_lvl});
            tick(1); chk("byp_new",  {31'd0, db_out}, {31'd0, inpad});
            chk("byp_rise", {31'd0, rise_pulse}, {31'd0, inpad});
            chk("byp_fall", {31'd0, fall_pulse}, {31'd0, ~inpad});
            old_lvl = inpad;
        end
        tick(2);
        chk("byp_evt",  {16'd0, evt_cnt},  32'd20);
        chk("sat_evt4", {28'd0, evt_cnt4}, 32'd15);

        // Leave bypass while high: no spurious pulse.
        inpad = 1'b1; tick(4);
        chk("byp_hi_db",  {31'd0, db_out},  32'd1);
        chk("byp_hi_evt", {16'd0, evt_cnt}, 32'd21);
        bypass = 1'b0; tick(10);
        chk("unbyp_db",   {31'd0, db_out}, 32'd1);
        chk("unbyp_rise", rise_seen, 32'd11);
        chk("unbyp_evt",  {16'd0, evt_cnt}, 32'd21);

        // Clear coinciding with a fall pulse drops the event.
        inpad = 1'b0;
        tick(6); chk("clr_db_e6", {31'd0, db_out}, 32'd1);
        tick(1); chk("clr_fall", {31'd0, fall_pulse}, 32'd1);
        evt_clr = 1'b1; evt_clr4 = 1'b1;
        tick(1); evt_clr = 1'b0; evt_clr4 = 1'b0;
        chk("clr_evt",  {16'd0, evt_cnt},  32'd0);
        chk("clr_evt4", {28'd0, evt_cnt4}, 32'd0);
        tick(2); chk("clr_hold", {16'd0, evt_cnt}, 32'd0);

        // Reset while qualifying a fall (S_CHK_LO, counter 2).
        inpad = 1'b1; tick(9);
        chk("pre_db",  {31'd0, db_out},  32'd1);
        chk("pre_evt", {16'd0, evt_cnt}, 32'd1);
        inpad = 1'b0; tick(4);
        chk("mid_db", {31'd0, db_out}, 32'd1);
        RSTN = 1'b0; #1;
        chk("arst_db",   {31'd0, db_out},   32'd0);
        chk("arst_evt",  {16'd0, evt_cnt},  32'd0);
        chk("arst_sync", {31'd0, sync_out}, 32'd0);
        tick(2); RSTN = 1'b1; tick(20);
        chk("post_db",   {31'd0, db_out},  32'd0);
        chk("post_evt",  {16'd0, evt_cnt}, 32'd0);
        chk("post_fall", fall_seen, 32'd11);
        chk("post_rise", rise_seen, 32'd12);
        chk("never_both", both_seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
